// File: rtl/avst_pattern_pkg.sv
// Shared constants, LFSR step and word expansion for the Avalon-ST pattern generator.
// The AVST_PATTERN_ERR_INJECT_EN macro is consumed by the lane and top files.
package avst_pattern_pkg;

    localparam logic [2:0] STATE_INIT = 3'h1;
    localparam logic [2:0] STATE_RUN  = 3'h2;
    localparam logic [2:0] STATE_DONE = 3'h4;

    localparam logic [31:0] LFSR_POLY     = 32'h0400_0007;
    localparam logic [31:0] SEED_ZERO_SUB = 32'h1;

    // Widest payload expand_word can serve; callers truncate to DATA_W
    localparam int EXP_MAX_W = 1024;

    typedef enum logic [2:0] {
        ST_IDLE = STATE_INIT,
        ST_RUN  = STATE_RUN,
        ST_DONE = STATE_DONE
    } state_t;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {s[30:0], 1'b0} ^ (s[31] ? LFSR_POLY : 32'h0);
    endfunction

    function automatic logic [EXP_MAX_W-1:0] expand_word(input logic [31:0] s);
        return {(EXP_MAX_W/64){~s, s}};
    endfunction

endpackage

// File: rtl/avst_pattern_lane.sv
// One Avalon-ST source lane: LFSR, beat counter, sop/eop framing.
// With AVST_PATTERN_ERR_INJECT_EN defined, one beat can be XOR-corrupted.
module avst_pattern_lane
    import avst_pattern_pkg::*;
#(
    parameter int DATA_W = 128,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic [31:0]       seed,
`ifdef AVST_PATTERN_ERR_INJECT_EN
    input  logic [LEN_W-1:0]  err_beat,
    input  logic [DATA_W-1:0] err_mask,
`endif
    output logic              valid,
    input  logic              ready,
    output logic [DATA_W-1:0] data,
    output logic              sop,
    output logic              eop,
    output logic              lane_done
);

    logic [31:0]       s;
    logic [LEN_W-1:0]  cnt;
    logic [LEN_W-1:0]  len_q;
    logic              fin;
    logic              xfer;
    logic              last;
    logic [DATA_W-1:0] word;

`ifdef AVST_PATTERN_ERR_INJECT_EN
    logic [LEN_W-1:0]  err_beat_q;
    logic [DATA_W-1:0] err_mask_q;
`endif

    assign xfer = valid & ready;
    assign last = (cnt == len_q - LEN_W'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s     <= '0;
            cnt   <= '0;
            len_q <= '0;
            valid <= 1'b0;
            fin   <= 1'b0;
`ifdef AVST_PATTERN_ERR_INJECT_EN
            err_beat_q <= '0;
            err_mask_q <= '0;
`endif
        end else if (start) begin
            s     <= seed;
            cnt   <= '0;
            len_q <= len;
            valid <= 1'b1;
            fin   <= 1'b0;
`ifdef AVST_PATTERN_ERR_INJECT_EN
            err_beat_q <= err_beat;
            err_mask_q <= err_mask;
`endif
        end else if (xfer) begin
            s   <= lfsr_next(s);
            cnt <= cnt + LEN_W'(1);
            if (last) begin
                valid <= 1'b0;
                fin   <= 1'b1;
            end
        end
    end

    always_comb begin
        word = DATA_W'(expand_word(s));
`ifdef AVST_PATTERN_ERR_INJECT_EN
        if (cnt == err_beat_q)
            word = word ^ err_mask_q;
`endif
        data = valid ? word : '0;
    end

    assign sop = valid & (cnt == '0);
    assign eop = valid & last;

    // Counts the final handshake itself so the FSM can leave RUN that cycle
    assign lane_done = fin | (xfer & last);

endmodule

// File: rtl/avst_pattern_gen.sv
// Two matched Avalon-ST pattern streams (data + compare) under one control FSM.
// Define AVST_PATTERN_ERR_INJECT_EN to add compare-lane error injection ports.
module avst_pattern_gen
    import avst_pattern_pkg::*;
#(
    parameter int DATA_W = 128,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ctl_start,
    input  logic [LEN_W-1:0]  ctl_len,
    input  logic [31:0]       ctl_seed,
`ifdef AVST_PATTERN_ERR_INJECT_EN
    input  logic [LEN_W-1:0]  ctl_err_beat,
    input  logic [DATA_W-1:0] ctl_err_mask,
`endif
    output logic              ctl_busy,
    output logic              ctl_done,
    output logic              aso_outdata_valid,
    input  logic              aso_outdata_ready,
    output logic [DATA_W-1:0] aso_outdata_data,
    output logic              aso_outdata_sop,
    output logic              aso_outdata_eop,
    output logic              aso_compdata_valid,
    input  logic              aso_compdata_ready,
    output logic [DATA_W-1:0] aso_compdata_data,
    output logic              aso_compdata_sop,
    output logic              aso_compdata_eop,
    output logic [3:0]        aso_status_data
);

    state_t      state;
    state_t      state_nxt;
    logic        accept;
    logic        done_out;
    logic        done_cmp;
    logic [31:0] seed_eff;

    assign seed_eff = (ctl_seed == '0) ? SEED_ZERO_SUB : ctl_seed;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (ctl_start && (ctl_len != '0)) begin
                    accept    = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (done_out && done_cmp)
                    state_nxt = ST_DONE;
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign ctl_busy        = (state != ST_IDLE);
    assign ctl_done        = (state == ST_DONE);
    assign aso_status_data = {1'b0, state};

    avst_pattern_lane #(.DATA_W(DATA_W), .LEN_W(LEN_W)) u_out (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (accept),
        .len       (ctl_len),
        .seed      (seed_eff),
`ifdef AVST_PATTERN_ERR_INJECT_EN
        .err_beat  ('0),
        .err_mask  ('0),
`endif
        .valid     (aso_outdata_valid),
        .ready     (aso_outdata_ready),
        .data      (aso_outdata_data),
        .sop       (aso_outdata_sop),
        .eop       (aso_outdata_eop),
        .lane_done (done_out)
    );

    avst_pattern_lane #(.DATA_W(DATA_W), .LEN_W(LEN_W)) u_cmp (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (accept),
        .len       (ctl_len),
        .seed      (seed_eff),
`ifdef AVST_PATTERN_ERR_INJECT_EN
        .err_beat  (ctl_err_beat),
        .err_mask  (ctl_err_mask),
`endif
        .valid     (aso_compdata_valid),
        .ready     (aso_compdata_ready),
        .data      (aso_compdata_data),
        .sop       (aso_compdata_sop),
        .eop       (aso_compdata_eop),
        .lane_done (done_cmp)
    );

endmodule

// File: tb/tb_avst_pattern_gen.sv
// Randomized self-checking bench for avst_pattern_gen against a packet-level model.
// Define AVST_PATTERN_ERR_INJECT_EN to also exercise compare-lane error injection.
module tb_avst_pattern_gen;

    localparam int DW = 128;
    localparam int LW = 16;

    logic          clk;
    logic          reset_n;
    logic          ctl_start;
    logic [LW-1:0] ctl_len;
    logic [31:0]   ctl_seed;
`ifdef AVST_PATTERN_ERR_INJECT_EN
    logic [LW-1:0] ctl_err_beat;
    logic [DW-1:0] ctl_err_mask;
`endif
    logic          ctl_busy;
    logic          ctl_done;
    logic          o_valid;
    logic          o_ready;
    logic [DW-1:0] o_data;
    logic          o_sop;
    logic          o_eop;
    logic          c_valid;
    logic          c_ready;
    logic [DW-1:0] c_data;
    logic          c_sop;
    logic          c_eop;
    logic [3:0]    status;

    int n_chk = 0;
    int n_err = 0;

    avst_pattern_gen #(.DATA_W(DW), .LEN_W(LW)) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .ctl_start          (ctl_start),
        .ctl_len            (ctl_len),
        .ctl_seed           (ctl_seed),
`ifdef AVST_PATTERN_ERR_INJECT_EN
        .ctl_err_beat       (ctl_err_beat),
        .ctl_err_mask       (ctl_err_mask),
`endif
        .ctl_busy           (ctl_busy),
        .ctl_done           (ctl_done),
        .aso_outdata_valid  (o_valid),
        .aso_outdata_ready  (o_ready),
        .aso_outdata_data   (o_data),
        .aso_outdata_sop    (o_sop),
        .aso_outdata_eop    (o_eop),
        .aso_compdata_valid (c_valid),
        .aso_compdata_ready (c_ready),
        .aso_compdata_data  (c_data),
        .aso_compdata_sop   (c_sop),
        .aso_compdata_eop   (c_eop),
        .aso_status_data    (status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_next(input logic [31:0] s);
        logic [31:0] r;
        r = s << 1;
        if (s[31]) r = r ^ 32'h0400_0007;
        return r;
    endfunction

    function automatic logic [127:0] ref_word(input logic [31:0] s);
        logic [63:0] p;
        p = {~s, s};
        return {p, p};
    endfunction

    // One packet: model builds the expected beat list, then each cycle both
    // lanes are checked independently while the readies follow 'mode'.
    task automatic run_packet(input int len, input logic [31:0] seed,
                              input int mode, input int eb,
                              input logic [127:0] mask);
        logic [31:0]  sq[$];
        logic [31:0]  s;
        logic [127:0] po, pc, w;
        logic         so, sc;
        int           io, ic, cyc, budget;
        s = (seed == 32'h0) ? 32'h1 : seed;
        for (int i = 0; i < len; i++) begin
            sq.push_back(s);
            s = ref_next(s);
        end
        ctl_start = 1'b1;
        ctl_len   = len[LW-1:0];
        ctl_seed  = seed;
`ifdef AVST_PATTERN_ERR_INJECT_EN
        ctl_err_beat = eb[LW-1:0];
        ctl_err_mask = mask;
`endif
        @(negedge clk);
        io = 0; ic = 0; cyc = 0; so = 0; sc = 0; po = '0; pc = '0;
        budget = 40 * len + 60;
        while (!(io == len && ic == len) && cyc < budget) begin
            ctl_start = ($urandom % 4 == 0);
            ctl_len   = LW'($urandom);
            ctl_seed  = $urandom;
`ifdef AVST_PATTERN_ERR_INJECT_EN
            ctl_err_beat = LW'($urandom);
            ctl_err_mask = {4{$urandom}};
`endif
            case (mode)
                0: begin o_ready = 1'b1; c_ready = 1'b1; end
                1: begin o_ready = 1'($urandom); c_ready = 1'($urandom); end
                default: begin o_ready = cyc[0]; c_ready = (cyc >= 20); end
            endcase
            #1;
            chk("run_busy", ctl_busy, 1'b1);
            chk("run_status", status, 4'h2);
            chk("run_no_done", ctl_done, 1'b0);
            chk("o_valid", o_valid, io < len);
            if (o_valid && io < len) begin
                chk("o_data", o_data, ref_word(sq[io]));
                chk("o_sop", o_sop, io == 0);
                chk("o_eop", o_eop, io == len - 1);
            end
            if (so) chk("o_hold", o_data, po);
            so = o_valid & ~o_ready;
            po = o_data;
            if (o_valid && o_ready) io++;
            chk("c_valid", c_valid, ic < len);
            if (c_valid && ic < len) begin
                w = ref_word(sq[ic]);
                if (ic == eb) w = w ^ mask;
                chk("c_data", c_data, w);
                chk("c_sop", c_sop, ic == 0);
                chk("c_eop", c_eop, ic == len - 1);
            end
            if (sc) chk("c_hold", c_data, pc);
            sc = c_valid & ~c_ready;
            pc = c_data;
            if (c_valid && c_ready) ic++;
            @(negedge clk);
            cyc++;
        end
        chk("timeout", cyc < budget, 1'b1);
        ctl_start = 1'b0;
        #1;
        chk("done_pulse", ctl_done, 1'b1);
        chk("done_status", status, 4'h4);
        chk("done_o_valid", o_valid, 1'b0);
        chk("done_c_valid", c_valid, 1'b0);
        @(negedge clk);
        #1;
        chk("idle_status", status, 4'h1);
        chk("idle_busy", ctl_busy, 1'b0);
        chk("idle_done", ctl_done, 1'b0);
    endtask

    initial begin
        int len;
        reset_n   = 1'b0;
        ctl_start = 1'b0;
        ctl_len   = '0;
        ctl_seed  = '0;
        o_ready   = 1'b1;
        c_ready   = 1'b1;
`ifdef AVST_PATTERN_ERR_INJECT_EN
        ctl_err_beat = '0;
        ctl_err_mask = '0;
`endif
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_status", status, 4'h1);
        chk("rst_busy", ctl_busy, 1'b0);
        chk("rst_done", ctl_done, 1'b0);
        chk("rst_o_valid", o_valid, 1'b0);
        chk("rst_c_valid", c_valid, 1'b0);
        chk("rst_o_data", o_data, 128'h0);

        // Seed 0 must behave as seed 1; beat values written out literally
        ctl_start = 1'b1; ctl_len = 16'd2; ctl_seed = 32'h0;
        @(negedge clk);
        ctl_start = 1'b0;
        #1;
        chk("d_beat0", o_data, 128'hFFFFFFFE_00000001_FFFFFFFE_00000001);
        chk("d_cbeat0", c_data, 128'hFFFFFFFE_00000001_FFFFFFFE_00000001);
        chk("d_sop0", o_sop, 1'b1);
        @(negedge clk);
        #1;
        chk("d_beat1", o_data, 128'hFFFFFFFD_00000002_FFFFFFFD_00000002);
        chk("d_eop1", o_eop, 1'b1);
        chk("d_cbeat1", c_data, 128'hFFFFFFFD_00000002_FFFFFFFD_00000002);
        @(negedge clk);
        #1;
        chk("d_done", ctl_done, 1'b1);
        @(negedge clk);
        #1;
        chk("d_done_gone", ctl_done, 1'b0);

        run_packet(2, 32'h1, 0, -1, '0);

        // Zero length start is ignored
        ctl_start = 1'b1; ctl_len = '0; ctl_seed = 32'h1234;
        @(negedge clk);
        ctl_start = 1'b0;
        repeat (3) begin
            #1;
            chk("len0_status", status, 4'h1);
            chk("len0_valid", o_valid | c_valid, 1'b0);
            chk("len0_done", ctl_done, 1'b0);
            @(negedge clk);
        end

        run_packet(8, $urandom, 2, -1, '0);

        // Reset in the middle of a packet, then restart cleanly
        ctl_start = 1'b1; ctl_len = 16'd10; ctl_seed = 32'hACE1;
        o_ready = 1'b1; c_ready = 1'b1;
        @(negedge clk);
        ctl_start = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_o_valid", o_valid, 1'b0);
        chk("mid_rst_c_valid", c_valid, 1'b0);
        chk("mid_rst_status", status, 4'h1);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        run_packet(4, 32'hACE1, 0, -1, '0);

`ifdef AVST_PATTERN_ERR_INJECT_EN
        run_packet(4, 32'h5A5A_0001, 0, 2, 128'h1);
`endif

        for (int p = 0; p < 12; p++) begin
            len = int'($urandom_range(1, 12));
`ifdef AVST_PATTERN_ERR_INJECT_EN
            run_packet(len, ($urandom % 5 == 0) ? 32'h0 : $urandom,
                       int'($urandom % 3), int'($urandom_range(0, 13)),
                       128'h1 << $urandom_range(0, 127));
`else
            run_packet(len, ($urandom % 5 == 0) ? 32'h0 : $urandom,
                       int'($urandom % 3), -1, '0);
`endif
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/avst_pattern_gen.md
Name: avst_pattern_gen

Overview:
- Avalon-ST source that produces two matched 128-bit packet streams: a data stream and a compare stream.
- It is the transmitter for the stream comparator. It drives the comparator's indata and compdata sinks with identical pseudo-random packets.
- Each stream has its own ready, so the two sides advance independently under backpressure.
- Software/conduit control starts a packet of programmable length and seed, then observes busy/done.

Parameters:
- DATA_W, 128, stream data width; must be a multiple of 64.
- LEN_W, 16, width of the packet length (beats) field.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- ctl_start  in  1  start pulse; sampled only in IDLE
- ctl_len  in  LEN_W  packet length in beats
- ctl_seed  in  32  LFSR seed
- ctl_busy  out  1  high while not IDLE
- ctl_done  out  1  one-cycle pulse at packet completion
- aso_outdata_valid  out  1  data stream valid
- aso_outdata_ready  in  1  data stream ready
- aso_outdata_data  out  DATA_W  data stream payload
- aso_outdata_sop  out  1  data stream start of packet
- aso_outdata_eop  out  1  data stream end of packet
- aso_compdata_valid/ready/data/sop/eop  same directions and widths as outdata, for the compare stream
- aso_status_data  out  4  {1'b0, state one-hot}

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; all valid/sop/eop=0; data=0; ctl_busy=0; ctl_done=0.
  - Counters and LFSRs are cleared.
  - Reset mid-packet drops both valids immediately; no partial packet resumes.
- States, one-hot: IDLE=3'h1, RUN=3'h2, DONE=3'h4.
  - IDLE -> RUN: on ctl_start=1 with ctl_len!=0. Latch len and seed. If seed==0, substitute 32'h1.
  - ctl_start with ctl_len==0 is ignored: stay in IDLE, no done pulse.
  - ctl_start in RUN or DONE is ignored.
  - RUN -> DONE: when both lanes have transferred len beats. This can be the same cycle as the final handshake on either lane.
  - DONE -> IDLE: unconditionally after one cycle. ctl_done=1 only in DONE.
- Lane behaviour (identical for each stream, independent state):
  - 32-bit LFSR s and beat counter cnt are loaded at start (cnt=0).
  - valid rises the cycle after start is accepted; first beat latency is 1 clock.
  - Handshake: a beat transfers when valid&ready.
    - On transfer: s <= lfsr_next(s) and cnt <= cnt+1.
    - valid stays 1 until the beat with cnt==len-1 transfers, then drops the next cycle.
  - While valid&!ready, data/sop/eop are held stable. valid never drops before transfer.
  - sop = valid & (cnt==0). eop = valid & (cnt==len-1). len==1 gives sop=eop=1 on a single beat.
  - lfsr_next(s) = {s[30:0],1'b0} ^ (s[31] ? 32'h0400_0007 : 32'h0).
  - data = replicate {~s, s} DATA_W/64 times (MSB first).
  - A lane that finishes first idles (valid=0) until the other lane finishes.
- Full throughput: with ready tied high, a packet takes len cycles of valid, with no bubbles.
- aso_status_data tracks the state register directly.

Optional Feature:
- Macro: AVST_PATTERN_ERR_INJECT_EN.
- Defined:
  - Adds inputs ctl_err_beat [LEN_W] and ctl_err_mask [DATA_W], both latched at start.
  - On the compare lane only, the beat with cnt==ctl_err_beat carries data ^ mask.
  - A mask of 0 or err_beat>=len has no effect.
- Undefined:
  - Ports are absent.
  - The compare lane is bit-identical to the data lane.

Decomposition:
- Package avst_pattern_pkg holds:
  - state localparams STATE_INIT/RUN/DONE (1/2/4);
  - LFSR_POLY=32'h0400_0007 and SEED_ZERO_SUB=32'h1;
  - function lfsr_next;
  - function expand_word(s) producing DATA_W.
- Sub-module avst_pattern_lane:
  - contains the LFSR, counter, valid/sop/eop and optional error XOR;
  - instantiated twice by the top FSM;
  - reports lane_done.

Test Plan:
- Reset-idle: reset_n=0 then 1, no start -> all valids 0, aso_status_data=4'h1, ctl_busy=0.
- Seed 1, len 2, readies high:
  - beat0 = 0xFFFFFFFE_00000001_FFFFFFFE_00000001 with sop=1;
  - beat1 = 0xFFFFFFFD_00000002_FFFFFFFD_00000002 with eop=1;
  - ctl_done pulses 1 cycle after beat1 transfers.
- Seed 0 -> identical output to seed 1. ctl_len=0 with start -> stays IDLE, no valid, no done.
- Backpressure: len 8, outdata ready toggling every cycle, compdata ready held 0 for 20 cycles then high:
  - both streams deliver identical 8-beat sequences with data held stable during stalls;
  - done only after compdata eop.
- Reset mid-RUN after 3 beats of len 10 -> valids 0 immediately; a new start restarts at sop with the seed word.
- With AVST_PATTERN_ERR_INJECT_EN: err_beat=2, mask=128'h1, len 4 -> compdata beat2 differs from outdata only in bit 0; the other beats match.
